// File: rtl/tick_gen_pkg.sv
// Shared constants for the multi-channel tick generator: default counter width,
// the classic 100 MHz divisor values and the channel-select width helper.
package tick_gen_pkg;

   localparam int CNT_W_DEF = 27;

   localparam int DIV_1KHZ = 100000;
   localparam int DIV_2HZ  = 50000000;
   localparam int DIV_1HZ  = 100000000;

   // Channel-select width; a single channel still gets a 1-bit select.
   function automatic int ch_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/tick_chan.sv
// One tick channel: divisor register, counter, one-cycle tick flop and, when
// TICK_SQ_OUT_EN is defined, a square-wave flop toggled by each tick.
module tick_chan
   import tick_gen_pkg::*;
#(
   parameter int               CNT_W   = CNT_W_DEF,
   parameter logic [CNT_W-1:0] DEF_DIV = CNT_W'(DIV_1KHZ)
) (
   input  logic             high,
   input  logic             rst,
   input  logic             en,
   input  logic             sync,
   input  logic             wr,
   input  logic [CNT_W-1:0] wr_div,
   output logic             tick
`ifdef TICK_SQ_OUT_EN
   ,
   output logic             sq
`endif
);

   logic [CNT_W-1:0] div_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;
   logic [CNT_W-1:0] deff;
   logic [CNT_W-1:0] term_cnt;
   logic             term;
   logic             tick_reg;
   logic             tick_next;

   // Divisors 0 and 1 both mean "every enabled cycle"; >= catches a shrunken divisor.
   always_comb begin
      deff      = (div_reg < CNT_W'(2)) ? CNT_W'(1) : div_reg;
      term_cnt  = deff - CNT_W'(1);
      term      = (cnt_reg >= term_cnt);
      tick_next = en && term && !sync;
      cnt_next  = cnt_reg;
      if (sync || wr) begin
         cnt_next = '0;
      end else if (en) begin
         cnt_next = term ? '0 : cnt_reg + CNT_W'(1);
      end
   end

   always_ff @(posedge high or posedge rst) begin
      if (rst) begin
         div_reg  <= DEF_DIV;
         cnt_reg  <= '0;
         tick_reg <= 1'b0;
      end else begin
         if (wr) begin
            div_reg <= wr_div;
         end
         cnt_reg  <= cnt_next;
         tick_reg <= tick_next;
      end
   end

   assign tick = tick_reg;

`ifdef TICK_SQ_OUT_EN
   logic sq_reg;

   always_ff @(posedge high or posedge rst) begin
      if (rst) begin
         sq_reg <= 1'b0;
      end else if (sync || wr) begin
         sq_reg <= 1'b0;
      end else if (tick_next) begin
         sq_reg <= ~sq_reg;
      end
   end

   assign sq = sq_reg;
`endif

endmodule

// File: rtl/tick_gen.sv
// Multi-channel tick generator top: config write decode, ack flop and one
// tick_chan per channel. Defining TICK_SQ_OUT_EN adds the sq square-wave outputs.
module tick_gen
   import tick_gen_pkg::*;
#(
   parameter int                      NUM_CH  = 3,
   parameter int                      CNT_W   = CNT_W_DEF,
   parameter logic [NUM_CH*CNT_W-1:0] DEF_DIV = {27'(DIV_1HZ), 27'(DIV_2HZ), 27'(DIV_1KHZ)},
   localparam int                     CH_W    = ch_width(NUM_CH)
) (
   input  logic              high,
   input  logic              rst,
   input  logic [NUM_CH-1:0] en,
   input  logic              sync,
   input  logic              cfg_wr,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   output logic              cfg_ack,
   output logic [NUM_CH-1:0] tick
`ifdef TICK_SQ_OUT_EN
   ,
   output logic [NUM_CH-1:0] sq
`endif
);

   logic              cfg_valid;
   logic              cfg_ack_reg;
   logic [NUM_CH-1:0] wr_sel;

   // Extra bit so the range check stays meaningful when NUM_CH is a power of two.
   assign cfg_valid = cfg_wr && ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH));

   always_ff @(posedge high or posedge rst) begin
      if (rst) begin
         cfg_ack_reg <= 1'b0;
      end else begin
         cfg_ack_reg <= cfg_valid;
      end
   end

   assign cfg_ack = cfg_ack_reg;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
         assign wr_sel[gi] = cfg_valid && (cfg_ch == CH_W'(gi));

         tick_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV[gi*CNT_W +: CNT_W])
         ) u_chan (
            .high   (high),
            .rst    (rst),
            .en     (en[gi]),
            .sync   (sync),
            .wr     (wr_sel[gi]),
            .wr_div (cfg_div),
            .tick   (tick[gi])
`ifdef TICK_SQ_OUT_EN
            ,
            .sq     (sq[gi])
`endif
         );
      end
   endgenerate

endmodule

// File: doc/tick_gen.md
Name: tick_gen

Overview:
- Parametrised multi-channel tick generator; successor to the fixed three-rate divider off the 100 MHz system clock.
- Each channel emits a one-cycle `tick` pulse every `div[i]` clock cycles.
- Divisors reload at runtime through a strobe/ack config port; per-channel enable and a global resync are provided.
- Feeds display refresh, key scan and 1 Hz timekeeping logic.

Parameters:
- NUM_CH, 3, number of independent tick channels (1..16).
- CNT_W, 27, width of each divisor register and counter.
- DEF_DIV, {27'd100000000, 27'd50000000, 27'd100000}, reset divisors. Flattened NUM_CH*CNT_W vector; channel i occupies bits [i*CNT_W +: CNT_W].

Ports:
- high, input, 1, system clock (100 MHz).
- rst, input, 1, asynchronous reset, active-high.
- en, input, NUM_CH, per-channel count enable.
- sync, input, 1, clears all channel counters simultaneously.
- cfg_wr, input, 1, divisor write strobe, single cycle.
- cfg_ch, input, CH_W = max(1, clog2(NUM_CH)), target channel for the write.
- cfg_div, input, CNT_W, new divisor value.
- cfg_ack, output, 1, registered one-cycle acknowledge of a valid write.
- tick, output, NUM_CH, registered one-cycle pulse per channel.

Behaviour:
- Reset (async assert, sync release): `div[i]`=DEF_DIV slice, `cnt[i]`=0, `tick`=0, `cfg_ack`=0. Assertion mid-count clears everything immediately.
- Effective divisor: `deff` = (`div[i]` < 2) ? 1 : `div[i]`. Divisor 0 or 1 means tick on every enabled cycle.
- Counting, on each rising edge with `en[i]`=1:
  - If `cnt[i]` == `deff`-1: `cnt[i]`<=0 and `tick[i]`<=1.
  - Otherwise: `cnt[i]`<=`cnt[i]`+1 and `tick[i]`<=0.
- Period is exactly `deff` cycles and pulse width is exactly 1 cycle. With `en` high from reset release, the first tick is visible in the cycle after the `deff`-th edge.
- `en[i]`=0: `cnt[i]` holds and `tick[i]`<=0. Re-enable resumes from the held count; no catch-up pulses.
- `sync`=1: all `cnt`<=0, all `tick`<=0 that edge, regardless of `en`.
- Config write (`cfg_wr`=1, `cfg_ch` < NUM_CH):
  - `div[cfg_ch]`<=`cfg_div` and `cnt[cfg_ch]`<=0.
  - `cfg_ack`<=1 on the same edge, so ack is high for the next cycle only.
  - New period starts counting from that edge.
- Config write with `cfg_ch` >= NUM_CH: ignored; `cfg_ack` stays 0.
- Write on a channel's terminal-count cycle: tick still issues (decided by the old divisor), and the counter clears to 0 per the write.
- `sync` and `cfg_wr` in the same cycle: both take effect. Counters clear, the divisor updates and ack pulses.
- Back-to-back `cfg_wr` on consecutive cycles: each one is accepted and acked. Last write wins on the same channel.
- Counter arithmetic is unsigned CNT_W bits. `cnt` never exceeds `deff`-1, so there is no wrap past 2^CNT_W-1.
- If a divisor shrinks below the current `cnt` by any path, the compare is `cnt` >= `deff`-1, so it terminates at once (tick, clear). Only a write clears `cnt`, but the >= compare is mandatory.

Optional Feature:
- Macro: TICK_SQ_OUT_EN.
- Defined:
  - Adds output `sq` (NUM_CH bits).
  - `sq[i]` toggles on every edge that sets `tick[i]`, giving a square wave of period 2*`deff` at 50% duty.
  - Reset value 0. `sync` and a config write to channel i clear `sq[i]` to 0.
- Undefined: port `sq` and its flops are absent. All other behaviour is identical.

Decomposition:
- Package `tick_gen_pkg`:
  - CNT_W default.
  - Default divisor constants (DIV_1KHZ=100000, DIV_2HZ=50000000, DIV_1HZ=100000000).
  - CH_W clog2 helper function.
- Sub-module `tick_chan`: one divisor register, counter, tick flop and optional `sq` flop. Instantiated NUM_CH times via generate. Top level holds only write decode and the ack flop.

Test Plan (NUM_CH=3, CNT_W=8, DEF_DIV ch0=4 ch1=3 ch2=1):
- Reset release, `en`=3'b111 held 24 cycles -> `tick[0]` every 4 cycles, `tick[1]` every 3, `tick[2]` high every cycle; each pulse 1 cycle wide.
- `rst` asserted mid-count (ch0 `cnt`=2) -> `tick`=0 and counters 0 immediately; first `tick[0]` exactly 4 cycles after release.
- `cfg_wr` `cfg_ch`=1 `cfg_div`=5 -> `cfg_ack` high for 1 cycle the next cycle; `tick[1]` 5 cycles after the write edge, then every 5. Write with `cfg_ch`=3 -> no ack, no channel change.
- `en[0]`=0 for 7 cycles at `cnt`=1 -> no `tick[0]`; after re-enable, `tick[0]` after 3 more edges.
- `sync` pulsed while ch0 `cnt`=3 (terminal) -> no tick that edge; all channels restart, `tick[0]` 4 cycles later. `sync`+`cfg_wr`(ch0, div 2) same cycle -> ack asserted, `tick[0]` every 2.
- TICK_SQ_OUT_EN defined, ch0 `div`=4 -> `sq[0]` period 8 cycles at 50% duty, starting low after reset.
